// File: rtl/pipe_pkg.sv
// Shared definitions for the IF->ID pipeline stage: state encoding,
// the default bubble instruction and small helpers for field packing.
package pipe_pkg;

    // Stage occupancy states: no entry, main slot held, main+skid held.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_e;

    // Instruction word shown to decode when the stage holds nothing.
    localparam logic [31:0] NOP_IR = 32'h0000_0000;

    // Total width of one packed {pc_plus_4, ir, side} entry.
    function automatic int payload_w(input int pc_w, input int ir_w, input int side_w);
        return pc_w + ir_w + side_w;
    endfunction

    // Number of entries held in a given state.
    function automatic logic [1:0] occ_of(input stage_state_e st);
        logic [1:0] occ;
        case (st)
            ST_EMPTY: occ = 2'd0;
            ST_FULL:  occ = 2'd1;
            ST_SKID:  occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// Generic valid/data storage slot with load and clear; clear has priority
// so a flush can never be overridden by a simultaneous load.
module pipe_skid_slot #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] d_i,
    output logic         valid_o,
    output logic [W-1:0] q_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Valid flag: clear wins over load, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
        end else begin
            valid_q <= valid_q;
        end
    end

    // Payload: captured only on an effective load, untouched otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= {W{1'b0}};
        end else if (load_i && !clear_i) begin
            data_q <= d_i;
        end else begin
            data_q <= data_q;
        end
    end

    assign valid_o = valid_q;
    assign q_o     = data_q;

endmodule

// File: rtl/if_id_stage_buf.sv
// IF->ID pipeline stage with valid/ready handshake, optional 2-entry skid
// buffer (registered in_ready) and synchronous flush that inserts a bubble.
module if_id_stage_buf
    import pipe_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter int              IR_W      = 32,
    parameter int              SIDE_W    = 1,
    parameter bit              SKID_EN   = 1'b1,
    parameter logic [IR_W-1:0] BUBBLE_IR = IR_W'(NOP_IR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc_plus_4,
    input  logic [IR_W-1:0]   in_ir,
    input  logic [SIDE_W-1:0] in_side,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc_plus_4,
    output logic [IR_W-1:0]   out_ir,
    output logic [SIDE_W-1:0] out_side,
    output logic [1:0]        occupancy
);

    localparam int PAYLOAD_W = payload_w(PC_W, IR_W, SIDE_W);

    stage_state_e         state_q;
    stage_state_e         state_d;
    logic                 in_ready_q;

    logic                 in_xfer_s;
    logic                 out_xfer_s;
    logic                 m_load_s;
    logic                 m_from_s_s;
    logic                 m_clear_s;
    logic                 s_load_s;
    logic                 s_clear_s;
    logic                 m_valid_s;
    logic                 s_valid_s;
    logic [PAYLOAD_W-1:0] in_payload_s;
    logic [PAYLOAD_W-1:0] m_d_s;
    logic [PAYLOAD_W-1:0] m_q_s;
    logic [PAYLOAD_W-1:0] s_q_s;

    assign in_payload_s = {in_pc_plus_4, in_ir, in_side};
    assign m_d_s        = m_from_s_s ? s_q_s : in_payload_s;

    // With the skid slot in_ready comes straight from a flop; without it the
    // single slot can refill in the same cycle decode drains it.
    assign in_ready   = SKID_EN ? in_ready_q : (~m_valid_s | out_ready);
    assign in_xfer_s  = in_valid & in_ready;
    assign out_xfer_s = m_valid_s & out_ready;

    // Next-state and slot control decode; flush dominates every other event.
    always_comb begin
        state_d    = state_q;
        m_load_s   = 1'b0;
        m_from_s_s = 1'b0;
        m_clear_s  = 1'b0;
        s_load_s   = 1'b0;
        s_clear_s  = 1'b0;
        if (flush) begin
            state_d   = ST_EMPTY;
            m_clear_s = 1'b1;
            s_clear_s = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        state_d  = ST_FULL;
                        m_load_s = 1'b1;
                    end else begin
                        state_d  = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (in_xfer_s && out_xfer_s) begin
                        state_d  = ST_FULL;
                        m_load_s = 1'b1;
                    end else if (in_xfer_s && SKID_EN) begin
                        state_d  = ST_SKID;
                        s_load_s = 1'b1;
                    end else if (out_xfer_s) begin
                        state_d   = ST_EMPTY;
                        m_clear_s = 1'b1;
                    end else begin
                        state_d  = ST_FULL;
                    end
                end
                ST_SKID: begin
                    if (out_xfer_s && s_valid_s) begin
                        state_d    = ST_FULL;
                        m_load_s   = 1'b1;
                        m_from_s_s = 1'b1;
                        s_clear_s  = 1'b1;
                    end else if (out_xfer_s) begin
                        // Skid slot unexpectedly empty: recover to a clean state.
                        state_d   = ST_EMPTY;
                        m_clear_s = 1'b1;
                    end else begin
                        state_d  = ST_SKID;
                    end
                end
                default: begin
                    state_d   = ST_EMPTY;
                    m_clear_s = 1'b1;
                    s_clear_s = 1'b1;
                end
            endcase
        end
    end

    // State register; in_ready is precomputed from the next state so it
    // never depends combinationally on out_ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_SKID);
        end
    end

    pipe_skid_slot #(
        .W (PAYLOAD_W)
    ) u_main_slot (
        .clk     (clk),
        .rst_n   (reset),
        .load_i  (m_load_s),
        .clear_i (m_clear_s),
        .d_i     (m_d_s),
        .valid_o (m_valid_s),
        .q_o     (m_q_s)
    );

    if (SKID_EN) begin : g_skid
        pipe_skid_slot #(
            .W (PAYLOAD_W)
        ) u_skid_slot (
            .clk     (clk),
            .rst_n   (reset),
            .load_i  (s_load_s),
            .clear_i (s_clear_s),
            .d_i     (in_payload_s),
            .valid_o (s_valid_s),
            .q_o     (s_q_s)
        );
    end else begin : g_no_skid
        assign s_valid_s = 1'b0;
        assign s_q_s     = {PAYLOAD_W{1'b0}};
    end

    assign out_valid     = m_valid_s;
    assign out_pc_plus_4 = m_q_s[PAYLOAD_W-1 -: PC_W];
    assign out_ir        = m_valid_s ? m_q_s[SIDE_W +: IR_W] : BUBBLE_IR;
    assign out_side      = m_q_s[SIDE_W-1:0];
    assign occupancy     = occ_of(state_q);

endmodule

// File: tb/tb_if_id_stage_buf.sv
// Self-checking bench: directed vector table, hand sequences for reset,
// stall, flush and the no-skid build, then randomized traffic vs a queue model.
module tb_if_id_stage_buf;

    localparam logic [31:0] BUB0 = 32'h0000_0013;
    localparam logic [31:0] PCX  = 32'hA5A5_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // Skid build signals
    logic        iv1, rdy1, ordy1, fl1, ov1, side1_i;
    logic [31:0] pc1_i, ir1_i, pc1_o, ir1_o;
    logic [0:0]  side1_o;
    logic [1:0]  occ1;
    // Single-slot build signals
    logic        iv0, rdy0, ordy0, fl0, ov0, side0_i;
    logic [31:0] pc0_i, ir0_i, pc0_o, ir0_o;
    logic [0:0]  side0_o;
    logic [1:0]  occ0;

    if_id_stage_buf #(.PC_W(32), .IR_W(32), .SIDE_W(1), .SKID_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(rdy1),
        .in_pc_plus_4(pc1_i), .in_ir(ir1_i), .in_side(side1_i), .flush(fl1),
        .out_valid(ov1), .out_ready(ordy1), .out_pc_plus_4(pc1_o), .out_ir(ir1_o),
        .out_side(side1_o), .occupancy(occ1));

    if_id_stage_buf #(.PC_W(32), .IR_W(32), .SIDE_W(1), .SKID_EN(1'b0), .BUBBLE_IR(BUB0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(rdy0),
        .in_pc_plus_4(pc0_i), .in_ir(ir0_i), .in_side(side0_i), .flush(fl0),
        .out_valid(ov0), .out_ready(ordy0), .out_pc_plus_4(pc0_o), .out_ir(ir0_o),
        .out_side(side0_o), .occupancy(occ0));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] ir;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic [31:0] oir;
        logic [1:0]  occ;
        logic        rdy;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        side;
    } ent_t;

    vec_t vecs[24];
    ent_t q1[$];
    ent_t q0[$];

    function automatic vec_t mk(int iv, int ir, int ordy, int fl, int ov, int oir, int occ, int rdy);
        vec_t v;
        v.iv = 1'(iv); v.ir = 32'(ir); v.ordy = 1'(ordy); v.fl = 1'(fl);
        v.ov = 1'(ov); v.oir = 32'(oir); v.occ = 2'(occ); v.rdy = 1'(rdy);
        return v;
    endfunction

    task automatic idle_inputs();
        iv1 = 1'b0; ordy1 = 1'b0; fl1 = 1'b0; pc1_i = 32'h0; ir1_i = 32'h0; side1_i = 1'b0;
        iv0 = 1'b0; ordy0 = 1'b0; fl0 = 1'b0; pc0_i = 32'h0; ir0_i = 32'h0; side0_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        q1.delete();
        q0.delete();
    endtask

    initial begin
        int seq;
        logic       exp_r1, exp_r0, in_x1, in_x0, out_x1, out_x0;
        ent_t       e1, e0, h;
        logic [31:0] eir;

        // Directed vector table (applied to the skid build from empty)
        for (int k = 1; k <= 8; k++) vecs[k-1] = mk(1, k, 1, 0, 1, k, 1, 1);
        vecs[8]  = mk(0, 0,     1, 0, 0, 0,     0, 1);
        vecs[9]  = mk(1, 'hA,   0, 0, 1, 'hA,   1, 1);
        vecs[10] = mk(1, 'hB,   0, 0, 1, 'hA,   2, 0);
        vecs[11] = mk(0, 0,     0, 0, 1, 'hA,   2, 0);
        vecs[12] = mk(1, 'hD,   0, 0, 1, 'hA,   2, 0);
        vecs[13] = mk(0, 0,     1, 0, 1, 'hB,   1, 1);
        vecs[14] = mk(0, 0,     1, 0, 0, 0,     0, 1);
        vecs[15] = mk(1, 'h10,  0, 0, 1, 'h10,  1, 1);
        vecs[16] = mk(1, 'h11,  0, 0, 1, 'h10,  2, 0);
        vecs[17] = mk(1, 'hC,   0, 1, 0, 0,     0, 1);
        vecs[18] = mk(0, 0,     1, 0, 0, 0,     0, 1);
        vecs[19] = mk(1, 'h20,  0, 0, 1, 'h20,  1, 1);
        vecs[20] = mk(1, 'h21,  1, 1, 0, 0,     0, 1);
        vecs[21] = mk(0, 0,     0, 0, 0, 0,     0, 1);
        vecs[22] = mk(1, 'h22,  0, 1, 0, 0,     0, 1);
        vecs[23] = mk(1, 'h23,  0, 0, 1, 'h23,  1, 1);

        // Reset state while reset is held
        idle_inputs();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", ov1, 1'b0);
        chk("rst_out_ir", ir1_o, 32'h0);
        chk("rst_out_pc", pc1_o, 32'h0);
        chk("rst_out_side", side1_o, 1'b0);
        chk("rst_occ", occ1, 2'd0);
        chk("rst_nsk_out_ir", ir0_o, BUB0);
        chk("rst_nsk_valid", ov0, 1'b0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready_after_release", rdy1, 1'b1);
        chk("rst_occ_after_release", occ1, 2'd0);

        // Streaming, stall/skid, flush from the vector table
        do_reset();
        for (int i = 0; i < 24; i++) begin
            iv1 = vecs[i].iv; ir1_i = vecs[i].ir; pc1_i = vecs[i].ir ^ PCX;
            side1_i = vecs[i].ir[0]; ordy1 = vecs[i].ordy; fl1 = vecs[i].fl;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), ov1, vecs[i].ov);
            chk($sformatf("vec%0d_out_ir", i), ir1_o, vecs[i].oir);
            chk($sformatf("vec%0d_occ", i), occ1, vecs[i].occ);
            chk($sformatf("vec%0d_in_ready", i), rdy1, vecs[i].rdy);
            if (vecs[i].ov) begin
                chk($sformatf("vec%0d_pc", i), pc1_o, vecs[i].oir ^ PCX);
                chk($sformatf("vec%0d_side", i), side1_o, vecs[i].oir[0]);
            end
        end

        // Asynchronous reset with both slots full
        iv1 = 1'b1; ir1_i = 32'h30; pc1_i = 32'h30 ^ PCX; ordy1 = 1'b0; fl1 = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_pre_occ", occ1, 2'd2);
        #2 reset = 1'b0;
        #1;
        chk("midrst_out_valid", ov1, 1'b0);
        chk("midrst_out_ir", ir1_o, 32'h0);
        chk("midrst_occ", occ1, 2'd0);
        iv1 = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", rdy1, 1'b1);
        chk("midrst_still_empty", ov1, 1'b0);

        // Single-slot build: combinational ready and full throughput
        do_reset();
        iv0 = 1'b1; ir0_i = 32'h40; pc0_i = 32'h40 ^ PCX; ordy0 = 1'b0;
        @(posedge clk);
        #1;
        chk("nsk_load_ir", ir0_o, 32'h40);
        chk("nsk_stall_ready", rdy0, 1'b0);
        ordy0 = 1'b1;
        #1;
        chk("nsk_release_ready", rdy0, 1'b1);
        for (int k = 'h41; k <= 'h44; k++) begin
            ir0_i = 32'(k); pc0_i = 32'(k) ^ PCX;
            @(posedge clk);
            #1;
            chk($sformatf("nsk_stream_%0h", k), {ov0, occ0, ir0_o}, {1'b1, 2'd1, 32'(k)});
        end
        iv0 = 1'b0;
        @(posedge clk);
        #1;
        chk("nsk_drained", {ov0, occ0, ir0_o}, {1'b0, 2'd0, BUB0});

        // Randomized traffic against a queue model for both builds
        do_reset();
        seq = 1;
        for (int c = 0; c < 10000; c++) begin
            iv1 = ($urandom_range(0, 3) != 0); ordy1 = ($urandom_range(0, 2) != 0);
            fl1 = ($urandom_range(0, 31) == 0); ir1_i = 32'(seq); pc1_i = $urandom;
            side1_i = 1'($urandom_range(0, 1));
            iv0 = ($urandom_range(0, 3) != 0); ordy0 = ($urandom_range(0, 2) != 0);
            fl0 = ($urandom_range(0, 31) == 0); ir0_i = 32'(seq) | 32'h8000_0000; pc0_i = $urandom;
            side0_i = 1'($urandom_range(0, 1));
            seq++;
            #1;
            exp_r1 = (q1.size() < 2);
            exp_r0 = (q0.size() == 0) || ordy0;
            chk("rnd_in_ready_skid", rdy1, exp_r1);
            chk("rnd_in_ready_nsk", rdy0, exp_r0);
            in_x1 = iv1 && exp_r1; out_x1 = (q1.size() > 0) && ordy1;
            in_x0 = iv0 && exp_r0; out_x0 = (q0.size() > 0) && ordy0;
            e1 = '{pc: pc1_i, ir: ir1_i, side: side1_i};
            e0 = '{pc: pc0_i, ir: ir0_i, side: side0_i};
            @(posedge clk);
            if (out_x1) h = q1.pop_front();
            if (fl1) q1.delete(); else if (in_x1) q1.push_back(e1);
            if (out_x0) h = q0.pop_front();
            if (fl0) q0.delete(); else if (in_x0) q0.push_back(e0);
            #1;
            if (q1.size() > 0) begin
                chk("rnd_out_skid", {ov1, occ1, ir1_o, pc1_o, side1_o},
                    {1'b1, 2'(q1.size()), q1[0].ir, q1[0].pc, q1[0].side});
            end else begin
                eir = 32'h0;
                chk("rnd_out_skid", {ov1, occ1, ir1_o}, {1'b0, 2'd0, eir});
            end
            if (q0.size() > 0) begin
                chk("rnd_out_nsk", {ov0, occ0, ir0_o, pc0_o, side0_o},
                    {1'b1, 2'(q0.size()), q0[0].ir, q0[0].pc, q0[0].side});
            end else begin
                chk("rnd_out_nsk", {ov0, occ0, ir0_o}, {1'b0, 2'd0, BUB0});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
